// File: rtl/wb_ctrl_pkg.sv
// rtl/wb_ctrl_pkg.sv - shared states, opcode/funct and selector constants for the write-back sequencer
package wb_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DECODE   = 3'd1,
      WAIT_MEM = 3'd2,
      WRITE    = 3'd3,
      DONE     = 3'd4
   } wb_state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_DIV   = 6'h1A;

   localparam logic [1:0] SEL_RT   = 2'b00;
   localparam logic [1:0] SEL_RD   = 2'b01;
   localparam logic [1:0] SEL_R31  = 2'b10;

endpackage

// File: rtl/wb_class_decode.sv
// rtl/wb_class_decode.sv - combinational opcode/funct classifier for register write-back
module wb_class_decode
   import wb_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic       writes,
   output logic       is_load,
   output logic [1:0] sel
);

   always_comb begin
      writes  = 1'b0;
      is_load = 1'b0;
      sel     = SEL_RT;
      case (opcode)
         OP_RTYPE: begin
            // jr, mult and div leave the register file untouched (mult/div target hi/lo)
            if (!(funct == FN_JR || funct == FN_MULT || funct == FN_DIV)) begin
               writes = 1'b1;
               sel    = SEL_RD;
            end
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
            writes = 1'b1;
         end
         OP_LW: begin
            writes  = 1'b1;
            is_load = 1'b1;
         end
         OP_JAL: begin
            writes = 1'b1;
            sel    = SEL_R31;
         end
         default: begin
            writes = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/regdest_wb_controller.sv
// rtl/regdest_wb_controller.sv - multicycle write-back sequencer driving regdest select and reg_write
module regdest_wb_controller
   import wb_ctrl_pkg::*;
#(
   parameter int MEM_LATENCY = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       flush,
   output logic [1:0] seletor_regdest,
   output logic       reg_write,
   output logic       busy,
   output logic       done
);

   localparam bit         HAS_WAIT = (MEM_LATENCY > 0);
   localparam logic [3:0] LAT_M1   = HAS_WAIT ? 4'(MEM_LATENCY - 1) : 4'd0;

   wb_state_e  state;
   wb_state_e  state_next;
   logic [5:0] op_q;
   logic [5:0] fn_q;
   logic [3:0] cnt;
   logic       dec_writes;
   logic       dec_load;
   logic [1:0] dec_sel;

   wb_class_decode u_decode (
      .opcode  (op_q),
      .funct   (fn_q),
      .writes  (dec_writes),
      .is_load (dec_load),
      .sel     (dec_sel)
   );

   always_comb begin
      state_next = IDLE;
      case (state)
         IDLE:     state_next = (start && !flush) ? DECODE : IDLE;
         DECODE: begin
            if (flush)
               state_next = IDLE;
            else if (!dec_writes)
               state_next = DONE;
            else if (dec_load && HAS_WAIT)
               state_next = WAIT_MEM;
            else
               state_next = WRITE;
         end
         WAIT_MEM: state_next = flush ? IDLE : ((cnt == 4'd0) ? WRITE : WAIT_MEM);
         WRITE:    state_next = flush ? IDLE : DONE;
         DONE:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Only the write strobe is combinational so a squash can kill it in the same cycle
   assign reg_write = (state == WRITE) && !flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         op_q            <= 6'd0;
         fn_q            <= 6'd0;
         cnt             <= 4'd0;
         seletor_regdest <= SEL_RT;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next != IDLE);
         done  <= (state_next == DONE);

         if (state == IDLE && start && !flush) begin
            op_q <= opcode;
            fn_q <= funct;
         end

         if (state == DECODE && dec_load)
            cnt <= LAT_M1;
         else if (state == WAIT_MEM && cnt != 4'd0)
            cnt <= cnt - 4'd1;

         // Selector captured once in DECODE and held until the sequence ends or is squashed
         if (state_next == IDLE)
            seletor_regdest <= SEL_RT;
         else if (state == DECODE)
            seletor_regdest <= dec_sel;
      end
   end

endmodule

// File: tb/tb_regdest_wb_controller.sv
// tb/tb_regdest_wb_controller.sv - directed self-checking bench for regdest_wb_controller
module tb_regdest_wb_controller;

   logic       clk;
   logic       reset;
   logic       start;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       flush;

   logic [1:0] sel;
   logic       rw;
   logic       busy;
   logic       done;
   logic [1:0] sel0;
   logic       rw0;
   logic       busy0;
   logic       done0;

   int ncmp  = 0;
   int nfail = 0;

   logic [1:0] sel_a   [0:11];
   logic       rw_a    [0:11];
   logic       busy_a  [0:11];
   logic       done_a  [0:11];
   logic       rw0_a   [0:11];
   logic       done0_a [0:11];
   int         rw_cnt;
   int         done_cnt;

   regdest_wb_controller #(.MEM_LATENCY(2)) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .opcode          (opcode),
      .funct           (funct),
      .flush           (flush),
      .seletor_regdest (sel),
      .reg_write       (rw),
      .busy            (busy),
      .done            (done)
   );

   regdest_wb_controller #(.MEM_LATENCY(0)) dut0 (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .opcode          (opcode),
      .funct           (funct),
      .flush           (flush),
      .seletor_regdest (sel0),
      .reg_write       (rw0),
      .busy            (busy0),
      .done            (done0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Cycle k: drive inputs just after the edge, sample 1ns later, well away from the next edge
   task automatic run(input logic [5:0] op, input logic [5:0] fn,
                      input int slast, input int fc, input int rc, input int n);
      rw_cnt   = 0;
      done_cnt = 0;
      for (int k = 0; k < n; k++) begin
         start  = (k <= slast);
         opcode = op;
         funct  = fn;
         flush  = (k == fc);
         reset  = (k == rc);
         #1;
         sel_a[k]   = sel;
         rw_a[k]    = rw;
         busy_a[k]  = busy;
         done_a[k]  = done;
         rw0_a[k]   = rw0;
         done0_a[k] = done0;
         rw_cnt   += int'(rw);
         done_cnt += int'(done);
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      flush = 1'b0;
      reset = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      opcode = 6'd0;
      funct  = 6'd0;
      flush  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_sel",   32'(sel),   32'd0);
      chk("rst_rw",    32'(rw),    32'd0);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_done",  32'(done),  32'd0);
      chk("rst_busy0", 32'(busy0), 32'd0);
      chk("rst_sel0",  32'(sel0),  32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // add: DECODE c1, WRITE c2, DONE c3, IDLE c4
      run(6'h00, 6'h20, 0, -1, -1, 6);
      chk("add_busy_c1", 32'(busy_a[1]), 32'd1);
      chk("add_rw_c1",   32'(rw_a[1]),   32'd0);
      chk("add_rw_c2",   32'(rw_a[2]),   32'd1);
      chk("add_sel_c2",  32'(sel_a[2]),  32'd1);
      chk("add_done_c3", 32'(done_a[3]), 32'd1);
      chk("add_busy_c4", 32'(busy_a[4]), 32'd0);
      chk("add_sel_c4",  32'(sel_a[4]),  32'd0);
      chk("add_rw_cnt",  32'(rw_cnt),    32'd1);

      // lw: WAIT_MEM c2-c3 with latency 2; straight to WRITE with latency 0
      run(6'h23, 6'h00, 0, -1, -1, 8);
      chk("lw_rw_c2",    32'(rw_a[2]),    32'd0);
      chk("lw_rw_c4",    32'(rw_a[4]),    32'd1);
      chk("lw_sel_c4",   32'(sel_a[4]),   32'd0);
      chk("lw_done_c5",  32'(done_a[5]),  32'd1);
      chk("lw_busy_c6",  32'(busy_a[6]),  32'd0);
      chk("lw_rw_cnt",   32'(rw_cnt),     32'd1);
      chk("lw0_rw_c2",   32'(rw0_a[2]),   32'd1);
      chk("lw0_done_c3", 32'(done0_a[3]), 32'd1);

      run(6'h03, 6'h00, 0, -1, -1, 6);
      chk("jal_rw_c2",  32'(rw_a[2]),  32'd1);
      chk("jal_sel_c2", 32'(sel_a[2]), 32'd2);

      run(6'h00, 6'h08, 0, -1, -1, 6);
      chk("jr_rw_cnt",  32'(rw_cnt),    32'd0);
      chk("jr_done_c2", 32'(done_a[2]), 32'd1);
      chk("jr_sel_c2",  32'(sel_a[2]),  32'd0);

      run(6'h2B, 6'h00, 0, -1, -1, 6);
      chk("sw_rw_cnt",  32'(rw_cnt),    32'd0);
      chk("sw_done_c2", 32'(done_a[2]), 32'd1);

      // addi squashed in its WRITE cycle
      run(6'h08, 6'h00, 0, 2, -1, 6);
      chk("fl_busy_c2",  32'(busy_a[2]), 32'd1);
      chk("fl_rw_cnt",   32'(rw_cnt),    32'd0);
      chk("fl_done_cnt", 32'(done_cnt),  32'd0);
      chk("fl_busy_c3",  32'(busy_a[3]), 32'd0);

      // flush coinciding with start in IDLE drops the start
      run(6'h00, 6'h20, 0, 0, -1, 4);
      chk("idlefl_busy_c1", 32'(busy_a[1]), 32'd0);
      chk("idlefl_rw_cnt",  32'(rw_cnt),    32'd0);

      // start held c0-c4: accepted at c0 and again only at c4
      run(6'h00, 6'h20, 4, -1, -1, 10);
      chk("b2b_busy_c4",  32'(busy_a[4]), 32'd0);
      chk("b2b_rw_c6",    32'(rw_a[6]),   32'd1);
      chk("b2b_done_c7",  32'(done_a[7]), 32'd1);
      chk("b2b_rw_cnt",   32'(rw_cnt),    32'd2);

      // reset during WAIT_MEM of a lw
      run(6'h23, 6'h00, 0, -1, 2, 6);
      chk("mrst_busy_c2", 32'(busy_a[2]), 32'd1);
      chk("mrst_busy_c3", 32'(busy_a[3]), 32'd0);
      chk("mrst_sel_c3",  32'(sel_a[3]),  32'd0);
      chk("mrst_done_c3", 32'(done_a[3]), 32'd0);
      chk("mrst_rw_cnt",  32'(rw_cnt),    32'd0);

      run(6'h00, 6'h20, 0, -1, -1, 6);
      chk("post_rw_c2",  32'(rw_a[2]),  32'd1);
      chk("post_sel_c2", 32'(sel_a[2]), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
